pifo_deq_ctrl: RTL and testbench
================================

// Module: pifo_deq_ctrl
// PURPOSE
//  Dequeue-side controller for a register PIFO (insert/remove, rank_out/meta_out/valid_out).
//  Pops the PIFO head when downstream has room and presents entries as a valid/ready stream.
//  A 2-entry output buffer hides PIFO head-update latency; a gap counter paces output beats.
//  Sits between pifo_reg and the egress/output-queue logic of the switch.
// PARAMETERS
//  RANK_WIDTH  8  width of rank field
//  META_WIDTH  8  width of metadata field
//  PIFO_LAT    1  cycles after a remove before the PIFO head is valid again (>=1)
//  GAP_WIDTH   8  width of min_gap pacing input
// PORTS
//  clk        in   1           single clock; all logic on rising edge
//  rstn       in   1           synchronous, active-low reset
//  deq_en     in   1           0 = stop issuing new removes (buffered entries still drain)
//  min_gap    in   GAP_WIDTH   idle cycles forced between output beats (0 = back-to-back)
//  pifo_valid in   1           PIFO valid_out (head present)
//  pifo_rank  in   RANK_WIDTH  PIFO rank_out (head)
//  pifo_meta  in   META_WIDTH  PIFO meta_out (head)
//  pifo_remove out 1           remove pulse to PIFO
//  m_valid    out  1           output entry valid
//  m_ready    in   1           downstream accept
//  m_rank     out  RANK_WIDTH  output rank
//  m_meta     out  META_WIDTH  output metadata
//  occupancy  out  2           entries held in output buffer (0..2)
// BEHAVIOUR
//  Reset (rstn=0 at edge): buffer empty, FSM=IDLE, gap counter=0; outputs m_valid=0,
//   m_rank=0, m_meta=0, occupancy=0, pifo_remove=0. Reset mid-operation discards buffered entries.
//  pifo_remove combinational: = (state==IDLE) & pifo_valid & deq_en & (occupancy_next_free).
//   occupancy_next_free: occupancy<2, or occupancy==2 with an output handshake this cycle.
//  On a cycle with pifo_remove=1, {pifo_rank,pifo_meta} is written into buffer tail at that edge.
//  FSM: IDLE -> (remove) WAIT; WAIT counts PIFO_LAT cycles, no remove; -> IDLE.
//   Max pop rate = 1 per (PIFO_LAT+1) cycles.
//  Latency: remove cycle t -> m_valid=1 at t+1 if buffer was empty and gap counter is 0.
//  Output: m_valid = (occupancy>0) & (gap_cnt==0); head entry on m_rank/m_meta, stable while
//   m_valid & !m_ready (no change to data or valid until handshake).
//  Handshake m_valid&m_ready: pop head; gap_cnt loads min_gap (sampled at that edge);
//   gap_cnt decrements to 0 each cycle; min_gap=0 allows back-to-back beats.
//  Simultaneous write and pop: occupancy unchanged; ordering preserved (FIFO, oldest first).
//  Full (occupancy==2, no handshake): no remove. Empty PIFO: no remove, FSM stays IDLE.
//  deq_en falling in WAIT: WAIT completes, then holds IDLE. Entries already buffered still drain.
//  pifo_valid is sampled only in IDLE; a newly inserted lower rank during WAIT is seen next pop.
//  occupancy counter width 2; never exceeds 2 (assertion in bench).
// STRUCTURE
//  Shared pkg/header: PIFO_RANK_WIDTH, PIFO_META_WIDTH defaults, FSM state encodings (IDLE, WAIT).
//  One sub-module: pifo_deq_buf (2-entry synchronous FIFO with head register, push/pop/count).
//  Top holds FSM, PIFO_LAT wait counter, gap counter, remove logic.
// TESTING (bench instantiates pifo_reg L2_MAX_SIZE=3 + pifo_deq_ctrl; insert driven by bench)
//  1 Reset: hold rstn=0 3 cycles with pifo_valid=1 -> pifo_remove=0, m_valid=0, occupancy=0.
//  2 Insert ranks 87,54,76,47,29 (meta 30..80), m_ready=1, min_gap=0, deq_en=1 ->
//    output order ranks 29,47,54,76,87 with matching meta; one pifo_remove per PIFO_LAT+1 cycles.
//  3 m_ready=0 with 4 entries in PIFO -> exactly 2 removes, occupancy=2, m_rank stable;
//    m_ready=1 -> remaining 2 popped, total 4 beats in rank order, none lost or duplicated.
//  4 min_gap=3, 3 entries, m_ready=1 -> beats separated by exactly 3 m_valid=0 cycles.
//  5 deq_en=0 with rank 5 in PIFO -> no remove for 20 cycles; deq_en=1 -> remove next cycle,
//    m_valid with rank 5 one cycle later.
//  6 rstn=0 for 1 cycle while occupancy=2 -> next cycle occupancy=0, m_valid=0;
//    PIFO contents not re-requested until rstn=1 and FSM back in IDLE.

Source files
------------

// File: rtl/pifo_deq_ctrl_pkg.sv
// Shared widths and FSM encoding for the PIFO dequeue controller.
package pifo_deq_ctrl_pkg;
  localparam int PIFO_RANK_WIDTH = 8;
  localparam int PIFO_META_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } deq_state_t;
endpackage

// File: rtl/pifo_deq_buf.sv
// Two-entry FIFO with the oldest entry held in a head register.
module pifo_deq_buf
  import pifo_deq_ctrl_pkg::*;
#(
  parameter int WIDTH = PIFO_RANK_WIDTH + PIFO_META_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] tail;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          // a push into a full buffer is dropped; the controller never issues one
          if (count == 2'd0) begin
            head  <= din;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            tail  <= din;
            count <= 2'd2;
          end
        end
        2'b01: begin
          if (count != 2'd0) begin
            head  <= tail;
            count <= count - 2'd1;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head  <= din;
            count <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/pifo_deq_ctrl.sv
// Pops the PIFO head into a 2-entry output buffer and streams it out with
// optional pacing between beats.
//   state   | meaning
//   ST_IDLE | may issue a remove when the PIFO has a head and the buffer has room
//   ST_WAIT | PIFO head is updating after a remove; no remove issued
module pifo_deq_ctrl
  import pifo_deq_ctrl_pkg::*;
#(
  parameter int RANK_WIDTH = PIFO_RANK_WIDTH,
  parameter int META_WIDTH = PIFO_META_WIDTH,
  parameter int PIFO_LAT   = 1,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  deq_en,
  input  logic [GAP_WIDTH-1:0]  min_gap,
  input  logic                  pifo_valid,
  input  logic [RANK_WIDTH-1:0] pifo_rank,
  input  logic [META_WIDTH-1:0] pifo_meta,
  output logic                  pifo_remove,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [RANK_WIDTH-1:0] m_rank,
  output logic [META_WIDTH-1:0] m_meta,
  output logic [1:0]            occupancy
);
  localparam int LAT_W = (PIFO_LAT > 1) ? $clog2(PIFO_LAT) : 1;

  deq_state_t                       state;
  logic [LAT_W-1:0]                 lat_cnt;
  logic [GAP_WIDTH-1:0]             gap_cnt;
  logic [RANK_WIDTH+META_WIDTH-1:0] head;
  logic                             handshake;
  logic                             has_room;

  assign m_valid     = (occupancy != 2'd0) && (gap_cnt == '0);
  assign handshake   = m_valid & m_ready;
  // a full buffer still accepts when its head leaves on the same edge
  assign has_room    = (occupancy != 2'd2) | handshake;
  assign pifo_remove = rstn & (state == ST_IDLE) & pifo_valid & deq_en & has_room;
  assign {m_rank, m_meta} = head;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pifo_remove) begin
            state   <= ST_WAIT;
            lat_cnt <= LAT_W'(PIFO_LAT - 1);
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) state <= ST_IDLE;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)               gap_cnt <= '0;
    else if (handshake)      gap_cnt <= min_gap;
    else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 1'b1;
  end

  pifo_deq_buf #(
    .WIDTH(RANK_WIDTH + META_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rstn  (rstn),
    .push  (pifo_remove),
    .pop   (handshake),
    .din   ({pifo_rank, pifo_meta}),
    .head  (head),
    .count (occupancy)
  );
endmodule

// File: tb/tb_pifo_deq_ctrl.sv
// Bench for pifo_deq_ctrl: behavioural sorted-queue PIFO, scoreboard and
// cycle-level rule model, directed scenarios followed by random traffic.
module tb_pifo_deq_ctrl;
  localparam int RW  = 8;
  localparam int MW  = 8;
  localparam int LAT = 1;
  localparam int GW  = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          deq_en = 1'b1;
  logic [GW-1:0] min_gap = '0;
  logic          pifo_valid = 1'b0;
  logic [RW-1:0] pifo_rank = '0;
  logic [MW-1:0] pifo_meta = '0;
  logic          pifo_remove;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [RW-1:0] m_rank;
  logic [MW-1:0] m_meta;
  logic [1:0]    occupancy;

  int errors = 0;
  int checks = 0;

  pifo_deq_ctrl #(
    .RANK_WIDTH(RW), .META_WIDTH(MW), .PIFO_LAT(LAT), .GAP_WIDTH(GW)
  ) dut (
    .clk(clk), .rstn(rstn), .deq_en(deq_en), .min_gap(min_gap),
    .pifo_valid(pifo_valid), .pifo_rank(pifo_rank), .pifo_meta(pifo_meta),
    .pifo_remove(pifo_remove), .m_valid(m_valid), .m_ready(m_ready),
    .m_rank(m_rank), .m_meta(m_meta), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // PIFO model: sorted queue, head hidden for LAT cycles after each remove
  logic [15:0] pq[$];
  int          busy = 0;
  int          ins_k;
  logic        ins_v = 1'b0;
  logic [7:0]  ins_r = '0;
  logic [7:0]  ins_m = '0;

  always @(posedge clk) begin
    if (pifo_remove && pq.size() > 0) begin
      pq.delete(0);
      busy = LAT;
    end else if (busy > 0) begin
      busy--;
    end
    if (ins_v) begin
      ins_k = pq.size();
      for (int i = 0; i < pq.size(); i++)
        if (pq[i][15:8] > ins_r) begin ins_k = i; break; end
      pq.insert(ins_k, {ins_r, ins_m});
    end
    pifo_valid <= (pq.size() > 0) && (busy == 0);
    pifo_rank  <= (pq.size() > 0) ? pq[0][15:8] : '0;
    pifo_meta  <= (pq.size() > 0) ? pq[0][7:0] : '0;
  end

  // Reference model + scoreboard, evaluated mid-cycle
  logic [15:0] exp_q[$];
  int beat_r[$];
  int beat_m[$];
  int beat_c[$];
  int rm_c[$];
  int since_beat = 1000;
  int since_rm = 1000;
  int gap_m = 0;
  int cyc = 0;
  int rm_count = 0;
  logic exp_valid, exp_hs, exp_rm;

  always @(negedge clk) begin
    cyc++;
    exp_valid = (exp_q.size() > 0) && (since_beat > gap_m);
    exp_hs    = exp_valid && m_ready;
    exp_rm    = rstn && pifo_valid && deq_en && (since_rm > LAT) &&
                ((exp_q.size() < 2) || exp_hs);
    chk("m_valid", m_valid, exp_valid);
    chk("pifo_remove", pifo_remove, exp_rm);
    chk("occupancy", occupancy, exp_q.size());
    chk("occ_le2", occupancy != 2'd3, 1);
    if (exp_valid) begin
      chk("head_rank", m_rank, exp_q[0][15:8]);
      chk("head_meta", m_meta, exp_q[0][7:0]);
    end
    if (m_valid && m_ready) begin
      beat_r.push_back(m_rank);
      beat_m.push_back(m_meta);
      beat_c.push_back(cyc);
    end
    if (pifo_remove) begin
      rm_count++;
      rm_c.push_back(cyc);
    end
    if (!rstn) begin
      exp_q.delete();
      since_beat = 1000;
      since_rm   = 1000;
      gap_m      = 0;
    end else begin
      if (exp_hs) begin
        void'(exp_q.pop_front());
        since_beat = 1;
        gap_m      = min_gap;
      end else if (since_beat < 1000) since_beat++;
      if (exp_rm) begin
        exp_q.push_back({pifo_rank, pifo_meta});
        since_rm = 1;
      end else if (since_rm < 1000) since_rm++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic insert(input int r, input int m);
    ins_v = 1'b1; ins_r = 8'(r); ins_m = 8'(m);
    tick(1);
    ins_v = 1'b0;
  endtask

  task automatic clear_logs();
    beat_r.delete(); beat_m.delete(); beat_c.delete(); rm_c.delete();
    rm_count = 0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((pq.size() != 0 || exp_q.size() != 0 || occupancy != 2'd0) && n < limit) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", n < limit, 1);
  endtask

  initial begin
    int e2r[5] = '{29, 47, 54, 76, 87};
    int e2m[5] = '{80, 68, 42, 55, 30};
    int e3r[4] = '{20, 40, 60, 90};
    int e4r[3] = '{3, 5, 7};

    // reset held with a PIFO head present
    insert(10, 1);
    tick(3);
    @(negedge clk);
    chk("rst_remove", pifo_remove, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_occ", occupancy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_drain(100);

    // five entries, sorted output, one remove per LAT+1 cycles
    deq_en = 1'b0;
    insert(87, 30); insert(54, 42); insert(76, 55); insert(47, 68); insert(29, 80);
    clear_logs();
    deq_en = 1'b1;
    wait_drain(200);
    chk("t2_beats", beat_r.size(), 5);
    for (int i = 0; i < 5 && i < beat_r.size(); i++) begin
      chk("t2_rank", beat_r[i], e2r[i]);
      chk("t2_meta", beat_m[i], e2m[i]);
    end
    for (int i = 1; i < rm_c.size(); i++) chk("t2_rm_spacing", rm_c[i] - rm_c[i-1], LAT + 1);

    // backpressure: buffer fills to two and holds its head
    m_ready = 1'b0; deq_en = 1'b0;
    insert(60, 1); insert(20, 2); insert(90, 3); insert(40, 4);
    clear_logs();
    deq_en = 1'b1;
    tick(10);
    @(negedge clk);
    chk("t3_rank_mid", m_rank, 20);
    @(posedge clk); #1;
    tick(10);
    @(negedge clk);
    chk("t3_removes", rm_count, 2);
    chk("t3_occ", occupancy, 2);
    chk("t3_rank_end", m_rank, 20);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain(200);
    chk("t3_beats", beat_r.size(), 4);
    for (int i = 0; i < 4 && i < beat_r.size(); i++) chk("t3_rank", beat_r[i], e3r[i]);

    // pacing with three idle cycles between beats
    deq_en = 1'b0; min_gap = 8'd3;
    insert(7, 9); insert(3, 8); insert(5, 7);
    clear_logs();
    deq_en = 1'b1;
    wait_drain(200);
    chk("t4_beats", beat_r.size(), 3);
    for (int i = 0; i < 3 && i < beat_r.size(); i++) chk("t4_rank", beat_r[i], e4r[i]);
    for (int i = 1; i < beat_c.size(); i++) chk("t4_gap", beat_c[i] - beat_c[i-1], 4);

    // deq_en low blocks removes; raising it removes at once
    min_gap = 8'd0;
    tick(5);
    deq_en = 1'b0;
    insert(5, 99);
    clear_logs();
    tick(20);
    chk("t5_no_remove", rm_count, 0);
    deq_en = 1'b1;
    @(negedge clk);
    chk("t5_remove", pifo_remove, 1);
    @(negedge clk);
    chk("t5_valid", m_valid, 1);
    chk("t5_rank", m_rank, 5);
    @(posedge clk); #1;
    wait_drain(50);

    // reset while the buffer is full
    m_ready = 1'b0; deq_en = 1'b0;
    insert(40, 1); insert(41, 2); insert(42, 3);
    deq_en = 1'b1;
    tick(8);
    @(negedge clk);
    chk("t6_occ_full", occupancy, 2);
    @(posedge clk); #1;
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_occ_rst", occupancy, 0);
    chk("t6_valid_rst", m_valid, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain(100);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) min_gap = 8'($urandom_range(0, 3));
      ins_v   = ($urandom_range(0, 2) == 0);
      ins_r   = 8'($urandom_range(0, 255));
      ins_m   = 8'($urandom_range(0, 255));
      m_ready = ($urandom_range(0, 3) != 0);
      deq_en  = ($urandom_range(0, 4) != 0);
      tick(1);
    end
    ins_v = 1'b0; m_ready = 1'b1; deq_en = 1'b1;
    wait_drain(3000);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
